// File: rtl/saph_fpu_issuer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : saph_fpu_issuer_pkg
//  Purpose  : Shared types and constants for the FPU issuer slice: the float
//             operand type, mode-code width and a support-decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package saph_fpu_issuer_pkg;

    // IEEE-754 single-precision bit pattern.
    typedef logic [31:0] float;

    localparam int c_mode_w    = 2;
    localparam int c_num_modes = 1 << c_mode_w;

    // One bit per mode code, set when the attached FPU implements that mode.
    function automatic logic mode_supported(input logic [c_num_modes-1:0] has_modes,
                                            input logic [c_mode_w-1:0]    mode);
        return has_modes[mode];
    endfunction

endpackage
`default_nettype wire

// File: rtl/saph_fpu_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module   : saph_fpi (interface)
//  Purpose  : GPU <-> FPU operation interface.
//  Signals  : d_trig/d_lhs/d_rhs/d_mode  - operation issue (GPU -> FPU)
//             d_ready                    - FPU can take an operation
//             q_trig/q_res               - result strobe, not stallable
//             has_modes                  - per-mode capability mask
//  Modports : GPU (issuer side), FPU (execution unit side)
//  Revision : 1.0 - initial release
// ============================================================================
interface saph_fpi;
    import saph_fpu_issuer_pkg::*;

    logic                   d_trig;
    float                   d_lhs;
    float                   d_rhs;
    logic [c_mode_w-1:0]    d_mode;
    logic                   d_ready;
    logic                   q_trig;
    float                   q_res;
    logic [c_num_modes-1:0] has_modes;

    modport GPU (
        output d_trig, d_lhs, d_rhs, d_mode,
        input  d_ready, q_trig, q_res, has_modes
    );

    modport FPU (
        input  d_trig, d_lhs, d_rhs, d_mode,
        output d_ready, q_trig, q_res, has_modes
    );

endinterface
`default_nettype wire

// File: rtl/saph_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : saph_sync_fifo
//  Purpose  : Single-clock FIFO with registered storage and a combinational
//             head. A push while full is ignored even if a pop happens in the
//             same cycle; a pop while empty is ignored.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             i_push, i_din  - write strobe and data
//             i_pop          - read strobe (advances head)
//             o_full/o_empty - status, o_count - occupancy
//             o_head         - oldest entry (valid when !o_empty)
//  Revision : 1.0 - initial release
// ============================================================================
module saph_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire T                         i_din,
    input  wire logic                     i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output T                              o_head
);

    localparam int                AW           = $clog2(DEPTH);
    localparam logic [AW:0]       c_full_count = (AW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/saph_fpu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : saph_fpu_issuer
//  Purpose  : GPU-side master of saph_fpi. Accepts tagged FP requests, issues
//             supported modes to the FPU with zero added latency, completes
//             unsupported modes locally with an error flag, and returns
//             responses in issue order. FPU results are always captured since
//             q_trig cannot be stalled.
//  Ports    : clk, rst                          - clock, sync active-high reset
//             req_valid/req_ready/req_*         - request channel
//             resp_valid/resp_ready/resp_*      - in-order response channel
//             busy                              - work outstanding
//             err_spurious                      - sticky: result with no op
//             fpu                               - saph_fpi GPU modport
//  Revision : 1.0 - initial release
// ============================================================================
module saph_fpu_issuer
    import saph_fpu_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                req_valid,
    output logic                     req_ready,
    input  wire float                req_lhs,
    input  wire float                req_rhs,
    input  wire logic [c_mode_w-1:0] req_mode,
    input  wire logic [TAG_W-1:0]    req_tag,
    output logic                     resp_valid,
    input  wire logic                resp_ready,
    output float                     resp_res,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     err_spurious,
    saph_fpi.GPU                     fpu
);

    localparam int AW = $clog2(DEPTH);

    // Order entry: caller tag plus whether the request bypassed the FPU.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             bypass;
    } saph_fpu_ord_t;

    logic           w_supported;
    logic           w_accept;
    logic           w_issue;
    logic           w_resp_fire;
    logic           w_q_valid;

    saph_fpu_ord_t  w_ord_din;
    saph_fpu_ord_t  w_ord_head;
    logic           w_ord_full;
    logic           w_ord_empty;
    logic [AW:0]    w_ord_count;

    float           w_res_head;
    logic           w_res_full;
    logic           w_res_empty;
    logic [AW:0]    w_res_count;

    logic [AW:0]    r_pend;
    logic           r_err_spurious;

    // ---------------- request / issue ----------------
    assign w_supported = mode_supported(fpu.has_modes, req_mode);
    assign req_ready   = !rst && !w_ord_full && (!w_supported || fpu.d_ready);
    assign w_accept    = req_valid && req_ready;
    assign w_issue     = w_accept && w_supported;

    assign fpu.d_trig  = w_issue;
    assign fpu.d_lhs   = req_lhs;
    assign fpu.d_rhs   = req_rhs;
    assign fpu.d_mode  = req_mode;

    assign w_ord_din   = '{tag: req_tag, bypass: !w_supported};

    // ---------------- response ----------------
    assign resp_valid  = !w_ord_empty && (w_ord_head.bypass || !w_res_empty);
    assign resp_tag    = w_ord_head.tag;
    assign resp_err    = w_ord_head.bypass;
    assign resp_res    = w_ord_head.bypass ? '0 : w_res_head;
    assign w_resp_fire = resp_valid && resp_ready;

    saph_sync_fifo #(
        .T     (saph_fpu_ord_t),
        .DEPTH (DEPTH)
    ) u_ord_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_ord_din),
        .i_pop   (w_resp_fire),
        .o_full  (w_ord_full),
        .o_empty (w_ord_empty),
        .o_count (w_ord_count),
        .o_head  (w_ord_head)
    );

    // Every q_trig is captured; a spurious result into a full FIFO is dropped
    // by the FIFO's own full guard.
    saph_sync_fifo #(
        .T     (float),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (fpu.q_trig),
        .i_din   (fpu.q_res),
        .i_pop   (w_resp_fire && !w_ord_head.bypass),
        .o_full  (w_res_full),
        .o_empty (w_res_empty),
        .o_count (w_res_count),
        .o_head  (w_res_head)
    );

    // ---------------- in-flight tracking ----------------
    // A q_trig only retires a pending op when one exists; otherwise it is
    // spurious (e.g. an op issued before reset) and only flags the error.
    assign w_q_valid = fpu.q_trig && (r_pend != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend         <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            if (fpu.q_trig && (r_pend == '0)) begin
                r_err_spurious <= 1'b1;
            end
            case ({w_issue, w_q_valid})
                2'b10:   r_pend <= r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

    assign err_spurious = r_err_spurious;
    assign busy         = (w_ord_count != '0) || (r_pend != '0);

    // Credit invariant: ops in the FPU plus buffered results never exceed the
    // order entries, so the result FIFO cannot overflow. Only meaningful while
    // no spurious result has been absorbed.
    logic [AW+1:0] w_credit_used;
    assign w_credit_used = {1'b0, r_pend} + {1'b0, w_res_count};

    always_ff @(posedge clk) begin
        if (!rst && !r_err_spurious) begin
            assert (w_credit_used <= {1'b0, w_ord_count});
            assert (!(fpu.q_trig && w_res_full));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_saph_fpu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_saph_fpu_issuer
//  Purpose  : Self-checking bench for saph_fpu_issuer. FPU model: latency 3,
//             result = lhs ^ rhs, modes 0..2 supported. Inputs are driven just
//             after the rising edge, everything is sampled on the falling
//             edge. Expected responses are queued on acceptance and compared
//             in order as responses are consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_saph_fpu_issuer;
    import saph_fpu_issuer_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req_valid;
    logic             req_ready;
    float             req_lhs;
    float             req_rhs;
    logic [1:0]       req_mode;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    float             resp_res;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic             busy;
    logic             err_spurious;

    saph_fpi fpu_if ();

    saph_fpu_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_lhs      (req_lhs),
        .req_rhs      (req_rhs),
        .req_mode     (req_mode),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_res     (resp_res),
        .resp_tag     (resp_tag),
        .resp_err     (resp_err),
        .busy         (busy),
        .err_spurious (err_spurious),
        .fpu          (fpu_if.GPU)
    );

    // ---------------- FPU model (not flushed by rst: models a late result) ----
    logic [3:0]     tb_modes   = 4'b0111;
    logic           tb_d_ready = 1'b1;
    logic [LAT-1:0] pipe_v     = '0;
    float           pipe_d [LAT];

    assign fpu_if.has_modes = tb_modes;
    assign fpu_if.d_ready   = tb_d_ready;
    assign fpu_if.q_trig    = pipe_v[LAT-1];
    assign fpu_if.q_res     = pipe_d[LAT-1];

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], fpu_if.d_trig};
        pipe_d[0] <= fpu_if.d_lhs ^ fpu_if.d_rhs;
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             err;
        float             res;
    } exp_t;

    exp_t sb [$];
    exp_t e_in;
    exp_t e_out;

    int n_acc   = 0;
    int n_dtrig = 0;
    int n_qtrig = 0;
    int n_resp  = 0;

    logic             prev_hold = 1'b0;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;
    float             prev_res;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (fpu_if.d_trig) n_dtrig++;
            if (fpu_if.q_trig) n_qtrig++;
            if (prev_hold) begin
                chk_eq("hold_valid", 64'(resp_valid), 64'd1);
                chk_eq("hold_tag",   64'(resp_tag),   64'(prev_tag));
                chk_eq("hold_err",   64'(resp_err),   64'(prev_err));
                chk_eq("hold_res",   64'(resp_res),   64'(prev_res));
            end
            if (req_valid && req_ready) begin
                n_acc++;
                e_in.tag = req_tag;
                e_in.err = !tb_modes[req_mode];
                e_in.res = e_in.err ? 32'h0 : (req_lhs ^ req_rhs);
                sb.push_back(e_in);
            end
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (sb.size() == 0) begin
                    chk_eq("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e_out = sb.pop_front();
                    chk_eq("resp_tag", 64'(resp_tag), 64'(e_out.tag));
                    chk_eq("resp_err", 64'(resp_err), 64'(e_out.err));
                    chk_eq("resp_res", 64'(resp_res), 64'(e_out.res));
                end
            end
            prev_hold = resp_valid && !resp_ready;
            prev_tag  = resp_tag;
            prev_err  = resp_err;
            prev_res  = resp_res;
        end
    end

    // ---------------- driver helpers (start/end at posedge + 1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input float l, input float r, input logic [1:0] m,
                           input logic [TAG_W-1:0] t);
        req_valid = 1'b1;
        req_lhs   = l;
        req_rhs   = r;
        req_mode  = m;
        req_tag   = t;
    endtask

    task automatic send(input float l, input float r, input logic [1:0] m,
                        input logic [TAG_W-1:0] t);
        bit done = 1'b0;
        int n    = 0;
        present(l, r, m, t);
        while (!done && n < 50) begin
            @(negedge clk);
            done = req_ready;
            step();
            n++;
        end
        if (!done) chk_eq("send_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            seen = resp_valid;
            step();
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk_eq("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Backpressure stream state.
    float             s_lhs  [6];
    logic [1:0]       s_mode [6];
    int               s_idx;
    logic             s_last_ready;

    task automatic stream_step();
        if (s_idx < 6) present(s_lhs[s_idx], 32'h0000_00F0, s_mode[s_idx], TAG_W'(8 + s_idx));
        else           req_valid = 1'b0;
        @(negedge clk);
        s_last_ready = req_ready;
        if (req_valid && req_ready) s_idx++;
        step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int a0, a1, a2, a3;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_lhs    = '0;
        req_rhs    = '0;
        req_mode   = '0;
        req_tag    = '0;
        resp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_req_ready",    64'(req_ready),     64'd0);
        chk_eq("rst_resp_valid",   64'(resp_valid),    64'd0);
        chk_eq("rst_resp_err",     64'(resp_err),      64'd0);
        chk_eq("rst_busy",         64'(busy),          64'd0);
        chk_eq("rst_err_spurious", 64'(err_spurious),  64'd0);
        chk_eq("rst_d_trig",       64'(fpu_if.d_trig), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Single supported op: result 4 cycles after the request cycle
        a0 = n_dtrig;
        send(32'h3F80_0000, 32'h0000_0001, 2'd0, 4'd5);
        chk_eq("single_dtrig", 64'(n_dtrig - a0), 64'd1);
        chk_eq("single_busy",  64'(busy),         64'd1);
        wait_resp(lat);
        chk_eq("single_latency", 64'(lat), 64'd4);
        drain(20);
        chk_eq("single_idle", 64'(busy), 64'd0);

        // Unsupported mode: completes next cycle, no FPU op
        a0 = n_dtrig;
        send(32'h1234_5678, 32'h0F0F_0F0F, 2'd3, 4'd9);
        wait_resp(lat);
        chk_eq("bypass_latency", 64'(lat),           64'd1);
        chk_eq("bypass_dtrig",   64'(n_dtrig - a0),  64'd0);
        drain(20);

        // Ordering across mixed bypass / FPU requests
        a0 = n_resp;
        send(32'hAAAA_0000, 32'h0000_5555, 2'd0, 4'd1);
        send(32'hBBBB_0000, 32'h0000_1111, 2'd3, 4'd2);
        send(32'hCCCC_0000, 32'h0000_2222, 2'd1, 4'd3);
        drain(50);
        chk_eq("order_count", 64'(n_resp - a0), 64'd3);

        // Backpressure: only DEPTH requests admitted while responses stall
        s_lhs[0] = 32'h1000_0001; s_mode[0] = 2'd0;
        s_lhs[1] = 32'h2000_0002; s_mode[1] = 2'd1;
        s_lhs[2] = 32'h3000_0003; s_mode[2] = 2'd3;
        s_lhs[3] = 32'h4000_0004; s_mode[3] = 2'd2;
        s_lhs[4] = 32'h5000_0005; s_mode[4] = 2'd0;
        s_lhs[5] = 32'h6000_0006; s_mode[5] = 2'd1;
        s_idx      = 0;
        resp_ready = 1'b0;
        a0 = n_acc;
        a1 = n_qtrig;
        a2 = n_resp;
        repeat (20) stream_step();
        chk_eq("bp_accepted",   64'(n_acc - a0),   64'd4);
        chk_eq("bp_req_ready",  64'(s_last_ready), 64'd0);
        chk_eq("bp_buffered",   64'(n_qtrig - a1), 64'd3);
        chk_eq("bp_resp_valid", 64'(resp_valid),   64'd1);
        resp_ready = 1'b1;
        a3 = 0;
        while (s_idx < 6 && a3 < 40) begin
            stream_step();
            a3++;
        end
        req_valid = 1'b0;
        chk_eq("bp_all_sent", 64'(s_idx), 64'd6);
        drain(60);
        chk_eq("bp_accepted_total", 64'(n_acc - a0),  64'd6);
        chk_eq("bp_responses",      64'(n_resp - a2), 64'd6);

        // FPU stall: supported request blocked, bypass request still admitted
        tb_d_ready = 1'b0;
        a0 = n_dtrig;
        a1 = n_acc;
        present(32'h7777_0000, 32'h0000_0007, 2'd0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("stall_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        present(32'h8888_0000, 32'h0000_0008, 2'd3, 4'd4);
        @(negedge clk);
        chk_eq("stall_bypass_ready", 64'(req_ready), 64'd1);
        step();
        present(32'h7777_0000, 32'h0000_0007, 2'd0, 4'd2);
        @(negedge clk);
        chk_eq("stall_req_ready_again", 64'(req_ready), 64'd0);
        step();
        chk_eq("stall_dtrig",    64'(n_dtrig - a0), 64'd0);
        chk_eq("stall_accepted", 64'(n_acc - a1),   64'd1);
        tb_d_ready = 1'b1;
        send(32'h7777_0000, 32'h0000_0007, 2'd0, 4'd2);
        drain(30);
        chk_eq("stall_dtrig_after", 64'(n_dtrig - a0), 64'd1);

        // Reset with an op in flight: the late result is spurious
        send(32'h9999_0000, 32'h0000_0009, 2'd0, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mid_rst_req_ready", 64'(req_ready), 64'd0);
        step();
        rst = 1'b0;
        chk_eq("post_rst_resp_valid", 64'(resp_valid),   64'd0);
        chk_eq("post_rst_busy",       64'(busy),         64'd0);
        chk_eq("post_rst_spurious",   64'(err_spurious), 64'd0);
        step();
        chk_eq("pre_qtrig_spurious",  64'(err_spurious), 64'd0);
        step();
        chk_eq("spurious_set",        64'(err_spurious), 64'd1);
        chk_eq("spurious_not_busy",   64'(busy),         64'd0);
        chk_eq("spurious_no_resp",    64'(resp_valid),   64'd0);
        repeat (5) step();
        chk_eq("spurious_sticky",     64'(err_spurious), 64'd1);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_eq("spurious_cleared",    64'(err_spurious), 64'd0);
        chk_eq("final_busy",          64'(busy),         64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
